// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: access types,
// FSM states and access-size helpers.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LD  = 3'd3;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] LWU = 3'd6;

   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;
   localparam logic [2:0] SD  = 3'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // log2 of the access size in bytes; reserved load code 7 behaves as LD
   function automatic logic [1:0] load_size(input logic [2:0] l_mux);
      case (l_mux)
         LB, LBU: load_size = 2'd0;
         LH, LHU: load_size = 2'd1;
         LW, LWU: load_size = 2'd2;
         default: load_size = 2'd3;
      endcase
   endfunction

   function automatic logic [1:0] store_size(input logic [2:0] s_mux);
      case (s_mux)
         SB:      store_size = 2'd0;
         SH:      store_size = 2'd1;
         SW:      store_size = 2'd2;
         default: store_size = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data replication and load
// extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_s_mux,
   input  logic [2:0]  i_st_off,
   input  logic [63:0] i_rs2,
   output logic [7:0]  o_wstrb,
   output logic [63:0] o_wdata,
   input  logic [2:0]  i_l_mux,
   input  logic [2:0]  i_ld_off,
   input  logic [63:0] i_rdata,
   output logic [63:0] o_ldata
);

   logic [63:0] w_shift;

   always_comb begin
      o_wstrb = 8'hFF;
      o_wdata = i_rs2;
      case (i_s_mux)
         SB: begin
            o_wstrb = 8'h01 << i_st_off;
            o_wdata = {8{i_rs2[7:0]}};
         end
         SH: begin
            o_wstrb = 8'h03 << i_st_off;
            o_wdata = {4{i_rs2[15:0]}};
         end
         SW: begin
            o_wstrb = 8'h0F << i_st_off;
            o_wdata = {2{i_rs2[31:0]}};
         end
         default: begin
            o_wstrb = 8'hFF;
            o_wdata = i_rs2;
         end
      endcase
   end

   assign w_shift = i_rdata >> {i_ld_off, 3'b000};

   always_comb begin
      o_ldata = w_shift;
      case (i_l_mux)
         LB:      o_ldata = {{56{w_shift[7]}},  w_shift[7:0]};
         LH:      o_ldata = {{48{w_shift[15]}}, w_shift[15:0]};
         LW:      o_ldata = {{32{w_shift[31]}}, w_shift[31:0]};
         LBU:     o_ldata = {56'd0, w_shift[7:0]};
         LHU:     o_ldata = {48'd0, w_shift[15:0]};
         LWU:     o_ldata = {32'd0, w_shift[31:0]};
         default: o_ldata = w_shift;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: req/ack handshake FSM, pipeline stall,
// misalignment detection and write-back value selection.
module mem_lsu
   import lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] M_alu_result_i,
   input  logic        M_reg_wen_i,
   input  logic        M_reg_mux_i,
   input  logic [4:0]  M_reg_waddr_i,
   input  logic        M_mem_wen_i,
   input  logic [63:0] M_mem_wdata_temp_i,
   input  logic [63:0] M_mem_addr_i,
   input  logic [2:0]  M_l_mux_i,
   input  logic [2:0]  M_s_mux_i,
   output logic        M_stall_o,
   output logic        misalign_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [63:0] dmem_addr_o,
   output logic [63:0] dmem_wdata_o,
   output logic [7:0]  dmem_wstrb_o,
   input  logic        dmem_ack_i,
   input  logic [63:0] dmem_rdata_i,
   output logic [63:0] W_reg_wdata_o,
   output logic        W_reg_wen_o,
   output logic [4:0]  W_reg_waddr_o
);

   lsu_state_e  r_state;
   logic        r_req;
   logic        r_we;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [7:0]  r_wstrb;
   logic [2:0]  r_off;
   logic [63:0] r_ldbuf;

   logic        w_access;
   logic [1:0]  w_size;
   logic        w_misalign;
   logic        w_go;
   logic [7:0]  w_wstrb;
   logic [63:0] w_wdata;
   logic [63:0] w_ldata;

   lsu_align u_align (
      .i_s_mux  (M_s_mux_i),
      .i_st_off (M_mem_addr_i[2:0]),
      .i_rs2    (M_mem_wdata_temp_i),
      .o_wstrb  (w_wstrb),
      .o_wdata  (w_wdata),
      .i_l_mux  (M_l_mux_i),
      .i_ld_off (r_off),
      .i_rdata  (dmem_rdata_i),
      .o_ldata  (w_ldata)
   );

   assign w_access = M_reg_mux_i | M_mem_wen_i;
   assign w_size   = M_mem_wen_i ? store_size(M_s_mux_i) : load_size(M_l_mux_i);

   always_comb begin
      w_misalign = 1'b0;
      case (w_size)
         2'd1:    w_misalign = M_mem_addr_i[0];
         2'd2:    w_misalign = |M_mem_addr_i[1:0];
         2'd3:    w_misalign = |M_mem_addr_i[2:0];
         default: w_misalign = 1'b0;
      endcase
      w_misalign = w_misalign & w_access;
   end

   assign w_go       = w_access & ~w_misalign;
   assign misalign_o = w_misalign;
   // Stall starts combinationally in IDLE so the M register holds from the first cycle
   assign M_stall_o  = ((r_state == IDLE) & w_go) | (r_state == REQ);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_off   <= '0;
         r_ldbuf <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
                  r_we    <= M_mem_wen_i;
                  r_addr  <= {M_mem_addr_i[63:3], 3'b000};
                  r_wstrb <= M_mem_wen_i ? w_wstrb : '0;
                  r_wdata <= w_wdata;
                  r_off   <= M_mem_addr_i[2:0];
               end
            end
            REQ: begin
               if (dmem_ack_i) begin
                  r_ldbuf <= w_ldata;
                  r_req   <= 1'b0;
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign dmem_req_o   = r_req;
   assign dmem_we_o    = r_we;
   assign dmem_addr_o  = r_addr;
   assign dmem_wdata_o = r_wdata;
   assign dmem_wstrb_o = r_wstrb;

   assign W_reg_wdata_o = M_reg_mux_i ? r_ldbuf : M_alu_result_i;
   assign W_reg_wen_o   = M_reg_wen_i & ~w_misalign;
   assign W_reg_waddr_o = M_reg_waddr_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed table-driven bench for mem_lsu with a responding memory stub.
module tb_mem_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [63:0] M_alu_result_i;
   logic        M_reg_wen_i;
   logic        M_reg_mux_i;
   logic [4:0]  M_reg_waddr_i;
   logic        M_mem_wen_i;
   logic [63:0] M_mem_wdata_temp_i;
   logic [63:0] M_mem_addr_i;
   logic [2:0]  M_l_mux_i;
   logic [2:0]  M_s_mux_i;
   logic        M_stall_o;
   logic        misalign_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [63:0] dmem_addr_o;
   logic [63:0] dmem_wdata_o;
   logic [7:0]  dmem_wstrb_o;
   logic        dmem_ack_i;
   logic [63:0] dmem_rdata_i;
   logic [63:0] W_reg_wdata_o;
   logic        W_reg_wen_o;
   logic [4:0]  W_reg_waddr_o;

   always #5 clk_i = ~clk_i;

   mem_lsu dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .M_alu_result_i     (M_alu_result_i),
      .M_reg_wen_i        (M_reg_wen_i),
      .M_reg_mux_i        (M_reg_mux_i),
      .M_reg_waddr_i      (M_reg_waddr_i),
      .M_mem_wen_i        (M_mem_wen_i),
      .M_mem_wdata_temp_i (M_mem_wdata_temp_i),
      .M_mem_addr_i       (M_mem_addr_i),
      .M_l_mux_i          (M_l_mux_i),
      .M_s_mux_i          (M_s_mux_i),
      .M_stall_o          (M_stall_o),
      .misalign_o         (misalign_o),
      .dmem_req_o         (dmem_req_o),
      .dmem_we_o          (dmem_we_o),
      .dmem_addr_o        (dmem_addr_o),
      .dmem_wdata_o       (dmem_wdata_o),
      .dmem_wstrb_o       (dmem_wstrb_o),
      .dmem_ack_i         (dmem_ack_i),
      .dmem_rdata_i       (dmem_rdata_i),
      .W_reg_wdata_o      (W_reg_wdata_o),
      .W_reg_wen_o        (W_reg_wen_o),
      .W_reg_waddr_o      (W_reg_waddr_o)
   );

   typedef struct {
      logic [63:0] alu;
      logic        wen;
      logic        mux;
      logic [4:0]  waddr;
      logic        mwen;
      logic [63:0] rs2;
      logic [63:0] addr;
      logic [2:0]  lm;
      logic [2:0]  sm;
      logic [63:0] rdata;
      int          delay;
      logic        exp_mis;
      int          exp_stall;
      logic [63:0] exp_daddr;
      logic        exp_we;
      logic [7:0]  exp_strb;
      logic [63:0] exp_dwdata;
      logic [63:0] exp_w;
      logic        exp_wen;
   } vec_t;

   localparam int unsigned NVEC = 15;
   vec_t vecs [NVEC];

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [63:0] alu, input logic wen, input logic mux, input logic [4:0] waddr,
      input logic mwen, input logic [63:0] rs2, input logic [63:0] addr,
      input logic [2:0] lm, input logic [2:0] sm, input logic [63:0] rdata, input int delay,
      input logic exp_mis, input int exp_stall, input logic [63:0] exp_daddr,
      input logic exp_we, input logic [7:0] exp_strb, input logic [63:0] exp_dwdata,
      input logic [63:0] exp_w, input logic exp_wen);
      vec_t v;
      v.alu = alu; v.wen = wen; v.mux = mux; v.waddr = waddr; v.mwen = mwen;
      v.rs2 = rs2; v.addr = addr; v.lm = lm; v.sm = sm; v.rdata = rdata;
      v.delay = delay; v.exp_mis = exp_mis; v.exp_stall = exp_stall;
      v.exp_daddr = exp_daddr; v.exp_we = exp_we; v.exp_strb = exp_strb;
      v.exp_dwdata = exp_dwdata; v.exp_w = exp_w; v.exp_wen = exp_wen;
      return v;
   endfunction

   task automatic drive_bubble();
      M_alu_result_i = '0; M_reg_wen_i = 1'b0; M_reg_mux_i = 1'b0; M_reg_waddr_i = '0;
      M_mem_wen_i = 1'b0; M_mem_wdata_temp_i = '0; M_mem_addr_i = '0;
      M_l_mux_i = '0; M_s_mux_i = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   stall_cnt;
      int   waitc;
      logic seen_req;
      logic req_ok;
      logic done;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(posedge clk_i); #1;
      M_alu_result_i = v.alu; M_reg_wen_i = v.wen; M_reg_mux_i = v.mux;
      M_reg_waddr_i = v.waddr; M_mem_wen_i = v.mwen; M_mem_wdata_temp_i = v.rs2;
      M_mem_addr_i = v.addr; M_l_mux_i = v.lm; M_s_mux_i = v.sm;
      #1;
      chk({tag, " misalign"}, 64'(misalign_o), 64'(v.exp_mis));
      stall_cnt = 0; waitc = 0; seen_req = 1'b0; req_ok = 1'b1; done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (M_stall_o) stall_cnt++;
         if (dmem_req_o) begin
            seen_req = 1'b1;
            if (dmem_addr_o !== v.exp_daddr || dmem_we_o !== v.exp_we ||
                dmem_wstrb_o !== v.exp_strb || dmem_wdata_o !== v.exp_dwdata) begin
               req_ok = 1'b0;
               $display("FAIL %s req_fields: got addr %h we %b strb %h wdata %h want addr %h we %b strb %h wdata %h",
                        tag, dmem_addr_o, dmem_we_o, dmem_wstrb_o, dmem_wdata_o,
                        v.exp_daddr, v.exp_we, v.exp_strb, v.exp_dwdata);
            end
            if (waitc == v.delay) begin
               dmem_ack_i = 1'b1;
               dmem_rdata_i = v.rdata;
            end else begin
               waitc++;
            end
         end
         if (!M_stall_o) begin
            done = 1'b1;
            chk({tag, " W_wdata"}, W_reg_wdata_o, v.exp_w);
            chk({tag, " W_wen"}, 64'(W_reg_wen_o), 64'(v.exp_wen));
            chk({tag, " W_waddr"}, 64'(W_reg_waddr_o), 64'(v.waddr));
         end else begin
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b0;
            #1;
         end
      end
      chk({tag, " completed"}, 64'(done), 64'(1));
      if (v.exp_stall == 0) begin
         @(posedge clk_i); #2;
         if (dmem_req_o) seen_req = 1'b1;
      end
      chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(v.exp_stall));
      chk({tag, " req_issued"}, 64'(seen_req), 64'(v.exp_stall != 0));
      n_chk++;
      if (!req_ok) n_bad++;
      drive_bubble();
   endtask

   initial begin
      vecs[0]  = mk(64'h1234, 1, 0, 5'd5, 0, 64'h0, 64'h0, 3'd0, 3'd0, 64'h0, 0,
                    0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h1234, 1);
      vecs[1]  = mk(64'h1003, 1, 1, 5'd6, 0, 64'h0, 64'h1003, 3'd0, 3'd0, 64'h0000_0000_8000_0000, 0,
                    0, 2, 64'h1000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1);
      vecs[2]  = mk(64'h1003, 1, 1, 5'd7, 0, 64'h0, 64'h1003, 3'd4, 3'd0, 64'h0000_0000_8000_0000, 0,
                    0, 2, 64'h1000, 0, 8'h00, 64'h0, 64'h80, 1);
      vecs[3]  = mk(64'h2006, 0, 0, 5'd0, 1, 64'hABCD, 64'h2006, 3'd0, 3'd1, 64'h0, 1,
                    0, 3, 64'h2000, 1, 8'hC0, 64'hABCD_ABCD_ABCD_ABCD, 64'h2006, 0);
      vecs[4]  = mk(64'h3000, 1, 1, 5'd8, 0, 64'h0, 64'h3000, 3'd3, 3'd0, 64'h0123_4567_89AB_CDEF, 4,
                    0, 6, 64'h3000, 0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1);
      vecs[5]  = mk(64'h4002, 1, 1, 5'd9, 0, 64'h0, 64'h4002, 3'd2, 3'd0, 64'h0, 0,
                    1, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
      vecs[6]  = mk(64'h5006, 1, 1, 5'd10, 0, 64'h0, 64'h5006, 3'd1, 3'd0, 64'h8001_0000_0000_0000, 0,
                    0, 2, 64'h5000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1);
      vecs[7]  = mk(64'h6004, 1, 1, 5'd11, 0, 64'h0, 64'h6004, 3'd6, 3'd0, 64'hDEAD_BEEF_0000_0000, 2,
                    0, 4, 64'h6000, 0, 8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF, 1);
      vecs[8]  = mk(64'h6004, 1, 1, 5'd12, 0, 64'h0, 64'h6004, 3'd2, 3'd0, 64'hDEAD_BEEF_0000_0000, 0,
                    0, 2, 64'h6000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1);
      vecs[9]  = mk(64'h7005, 0, 0, 5'd0, 1, 64'h1122_3344_5566_7788, 64'h7005, 3'd0, 3'd0, 64'h0, 0,
                    0, 2, 64'h7000, 1, 8'h20, 64'h8888_8888_8888_8888, 64'h7005, 0);
      vecs[10] = mk(64'h7004, 0, 0, 5'd0, 1, 64'h1122_3344_5566_7788, 64'h7004, 3'd0, 3'd2, 64'h0, 0,
                    0, 2, 64'h7000, 1, 8'hF0, 64'h5566_7788_5566_7788, 64'h7004, 0);
      vecs[11] = mk(64'h7008, 0, 0, 5'd0, 1, 64'h1122_3344_5566_7788, 64'h7008, 3'd0, 3'd3, 64'h0, 0,
                    0, 2, 64'h7008, 1, 8'hFF, 64'h1122_3344_5566_7788, 64'h7008, 0);
      vecs[12] = mk(64'h700C, 0, 0, 5'd0, 1, 64'h1122_3344_5566_7788, 64'h700C, 3'd0, 3'd3, 64'h0, 0,
                    1, 0, 64'h0, 0, 8'h00, 64'h0, 64'h700C, 0);
      vecs[13] = mk(64'h8000, 1, 1, 5'd13, 0, 64'h0, 64'h8000, 3'd7, 3'd0, 64'hFEDC_BA98_7654_3210, 0,
                    0, 2, 64'h8000, 0, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210, 1);
      vecs[14] = mk(64'h9002, 1, 1, 5'd14, 0, 64'h0, 64'h9002, 3'd5, 3'd0, 64'h0000_0000_F00D_0000, 0,
                    0, 2, 64'h9000, 0, 8'h00, 64'h0, 64'h0000_0000_0000_F00D, 1);

      rst_i = 1'b1;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = '0;
      drive_bubble();
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      #1;
      chk("rst req", 64'(dmem_req_o), 64'(0));
      chk("rst we", 64'(dmem_we_o), 64'(0));
      chk("rst addr", dmem_addr_o, 64'h0);
      chk("rst wdata", dmem_wdata_o, 64'h0);
      chk("rst wstrb", 64'(dmem_wstrb_o), 64'h0);
      chk("rst stall", 64'(M_stall_o), 64'(0));
      chk("rst misalign", 64'(misalign_o), 64'(0));
      chk("rst W_wdata", W_reg_wdata_o, 64'h0);

      for (int unsigned i = 0; i < NVEC; i++) run_vec(vecs[i], int'(i));

      // Reset while a load is outstanding, then a stray ack
      @(posedge clk_i); #1;
      M_reg_mux_i = 1'b1; M_reg_wen_i = 1'b1; M_reg_waddr_i = 5'd15;
      M_mem_addr_i = 64'h5000; M_l_mux_i = 3'd3;
      @(posedge clk_i); #2;
      chk("rstreq req_before", 64'(dmem_req_o), 64'(1));
      rst_i = 1'b1;
      M_mem_addr_i = 64'h5001;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      chk("rstreq req_after", 64'(dmem_req_o), 64'(0));
      chk("rstreq addr_after", dmem_addr_o, 64'h0);
      chk("rstreq stall_idle", 64'(M_stall_o), 64'(0));
      chk("rstreq ldbuf", W_reg_wdata_o, 64'h0);
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk_i); #1;
      dmem_ack_i = 1'b0;
      #1;
      chk("lateack req", 64'(dmem_req_o), 64'(0));
      chk("lateack stall", 64'(M_stall_o), 64'(0));
      chk("lateack ldbuf", W_reg_wdata_o, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit of the 64-bit RV64 five-stage pipeline. Consumes the EX/MEM pipeline register outputs and runs the data-memory request/acknowledge handshake. Stalls the pipeline while an access is outstanding. Produces the aligned, extended write-back value for the MEM/WB register.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; **synchronous, active-high**.
- M_alu_result_i  in  64  ALU result of the M-stage instruction.
- M_reg_wen_i  in  1  register write enable.
- M_reg_mux_i  in  1  1 = write-back from memory (load); 0 = from ALU.
- M_reg_waddr_i  in  5  destination register.
- M_mem_wen_i  in  1  1 = store.
- M_mem_wdata_temp_i  in  64  unaligned store data (rs2).
- M_mem_addr_i  in  64  byte address.
- M_l_mux_i  in  3  load type.
- M_s_mux_i  in  3  store type.
- M_stall_o  out  1  hold the IF..M pipeline registers.
- misalign_o  out  1  misaligned access detected; access dropped.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  64  doubleword-aligned address ({addr[63:3],3'b0}).
- dmem_wdata_o  out  64  lane-replicated store data.
- dmem_wstrb_o  out  8  byte strobes; 0 for reads.
- dmem_ack_i  in  1  access complete; read data valid this cycle.
- dmem_rdata_i  in  64  read doubleword.
- W_reg_wdata_o  out  64  write-back value.
- W_reg_wen_o  out  1  write enable to MEM/WB.
- W_reg_waddr_o  out  5  destination register to MEM/WB.

## Operation
- Load type encoding: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU; 7 reserved, treated as LD. Store type encoding: 0 SB, 1 SH, 2 SW, 3 SD.
- A load is flagged when M_reg_mux_i=1. A store is flagged when M_mem_wen_i=1. The access flag is load OR store.
- A bubble has all-zero fields and issues no access.
- Misaligned: an access not naturally aligned for its size (H: addr[0]; W: addr[1:0]; D: addr[2:0]).
  - misalign_o=1 combinationally.
  - No request is issued and M_stall_o=0.
  - W_reg_wen_o is forced to 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE: aligned access present → M_stall_o=1. Next state REQ; latch addr, we, wstrb, wdata and offset.
  - REQ: dmem_req_o=1 with the latched fields; M_stall_o=1. On dmem_ack_i, capture the extended load data into the load buffer and go to DONE. Otherwise stay in REQ with request fields held constant.
  - DONE: M_stall_o=0, so the M register advances at this edge. Next state IDLE.
- Store lanes, with off=addr[2:0]:
  - SB: wstrb=8'h01<<off, wdata={8{rs2[7:0]}}.
  - SH: wstrb=8'h03<<off, wdata={4{rs2[15:0]}}.
  - SW: wstrb=8'h0F<<off, wdata={2{rs2[31:0]}}.
  - SD: wstrb=8'hFF, wdata=rs2.
- Load: shift rdata right by off*8, take the low 8/16/32/64 bits, then sign-extend (signed types) or zero-extend (U types).
- Write-back: W_reg_wdata_o = M_reg_mux_i ? load buffer : M_alu_result_i. W_reg_wen_o = M_reg_wen_i & ~misalign_o. W_reg_waddr_o = M_reg_waddr_i.
- The W outputs are combinational. For loads they are valid only in DONE; MEM/WB captures them when M_stall_o=0.

## Timing
- Reset values: state IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, dmem_wstrb_o=0, load buffer=0. M_stall_o/misalign_o follow their combinational definitions and are 0 with bubble inputs.
- Non-memory instruction: 0 added cycles, M_stall_o=0.
- Memory op with ack in the first REQ cycle: 3 cycles total (IDLE, REQ, DONE), i.e. 2 stall cycles. Each ack wait cycle adds 1.
- dmem_ack_i in IDLE or DONE is ignored.
- rst_i in REQ: next cycle IDLE with dmem_req_o=0. Any late ack is ignored.
- The inputs are stable while M_stall_o=1, because the M register holds its contents.

## Structure
- Shared package `lsu_pkg`:
  - load/store type localparams (LB..LWU, SB..SD);
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
- One natural sub-module, `lsu_align`: purely combinational store-lane generation and load extraction/extension. The FSM and registers stay in mem_lsu.

## Test plan
- ADD result 0x1234, reg_wen=1, waddr=5, no mem → W_reg_wdata_o=0x1234, W_reg_wen_o=1, M_stall_o=0, dmem_req_o never asserts.
- LB addr 0x1003, rdata 0x00000000_80000000 (byte 3 = 0x80), ack in first REQ cycle → stall high 2 cycles; in DONE W_reg_wdata_o=0xFFFF_FFFF_FFFF_FF80. Same data as LBU → 0x80.
- SH addr 0x2006, rs2=0xABCD → dmem_addr_o=0x2000, wstrb=8'hC0, wdata=0xABCD_ABCD_ABCD_ABCD, we=1.
- LD addr 0x3000, ack delayed 4 cycles → request fields constant throughout; stall length 6; W_reg_wdata_o=rdata.
- LW addr 0x4002 → misalign_o=1, no request, M_stall_o=0, W_reg_wen_o=0.
- LD in REQ, rst_i pulsed, then ack arrives → dmem_req_o=0 after reset, state IDLE, load buffer 0, ack ignored.
